// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the core memory stage and a
// word-wide data memory using a req/gnt/rvalid handshake. One access is in
// flight at a time. Loads are lane-shifted and sign/zero extended using the
// 3-bit size code (0=B, 1=H, 2=W, 3=BU, 4=HU, 5-7=W).
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split accesses that straddle a
// word boundary into two aligned transactions. Without it such accesses are
// rejected straight from IDLE with rsp_err and never touch memory.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  // access size in bytes for a size/sign code
  function automatic logic [2:0] sel_size(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd3: sel_size = 3'd1;
      3'd1, 3'd4: sel_size = 3'd2;
      default:    sel_size = 3'd4;
    endcase
  endfunction

  // true when the access spills past the end of its word
  function automatic logic is_mis(input logic [2:0] sel, input logic [1:0] off);
    is_mis = ({1'b0, off} + sel_size(sel)) > 3'd4;
  endfunction

  state_t              state_q, state_d;
  logic                we_q;
  logic [2:0]          sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0]   hi_q;
`else
  logic                err_q;
`endif

  logic [1:0]          off;
  logic [2:0]          size;
  logic [ADDR_W-1:0]   word_addr;
  logic [3:0]          be0;
  logic [DATA_W-1:0]   wd0;
  logic [DATA_W-1:0]   ld_word;
  logic [DATA_W-1:0]   ld_ext;

  assign off       = addr_q[1:0];
  assign size      = sel_size(sel_q);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
  // 8-lane window across the two words; phase 0 uses the low half, phase 1 the high
  logic [7:0]          mask;
  logic [2*DATA_W-1:0] wide_wdata;
  logic [3:0]          be1;
  logic [DATA_W-1:0]   wd1;
  logic                split;

  assign mask       = ((8'd1 << size) - 8'd1) << off;
  assign wide_wdata = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  assign be0        = mask[3:0];
  assign be1        = mask[7:4];
  assign wd0        = wide_wdata[DATA_W-1:0];
  assign wd1        = wide_wdata[2*DATA_W-1:DATA_W];
  assign split      = is_mis(sel_q, off);
  assign ld_word    = DATA_W'({hi_q, lo_q} >> {off, 3'b000});
`else
  // only word-contained accesses reach memory, so one word covers every lane
  assign be0        = 4'(((8'd1 << size) - 8'd1) << off);
  assign wd0        = wdata_q << {off, 3'b000};
  assign ld_word    = lo_q >> {off, 3'b000};
`endif

  // sign or zero extend the right-justified load data
  always_comb begin
    ld_ext = ld_word;
    case (sel_q)
      3'd0:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'd1:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'd3:    ld_ext = {24'd0, ld_word[7:0]};
      3'd4:    ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // state register plus request latch and read-data buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      hi_q    <= '0;
`else
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        sel_q   <= req_sel;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        lo_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        // non-split loads merge against a zero high word
        hi_q    <= '0;
`else
        err_q   <= is_mis(req_sel, req_addr[1:0]);
`endif
      end
      if (state_q == WAIT0 && mem_rvalid) lo_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == WAIT1 && mem_rvalid) hi_q <= mem_rdata;
`endif
    end
  end

  // next state and all outputs; request fields come from latched state so they
  // cannot move while mem_req waits for mem_gnt
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'd0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = ISSUE0;
`else
          state_d = is_mis(req_sel, req_addr[1:0]) ? RESP : ISSUE0;
`endif
        end
      end
      ISSUE0: begin
        mem_req   = 1'b1;
        mem_addr  = word_addr;
        mem_we    = we_q;
        mem_be    = be0;
        mem_wdata = wd0;
        if (mem_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = split ? ISSUE1 : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE1: begin
        mem_req   = 1'b1;
        mem_addr  = word_addr + ADDR_W'(4);
        mem_we    = we_q;
        mem_be    = be1;
        mem_wdata = wd1;
        if (mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) state_d = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (!we_q) rsp_rdata = ld_ext;
`else
        rsp_err   = err_q;
        if (!we_q && !err_q) rsp_rdata = ld_ext;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
